// File: rtl/ahb_bus_decoder_param_pkg.sv
// Shared AHB bus definitions for the parametrised decoder: transfer/response
// encodings, the default five-slave address map and the data-phase state types.
package ahb_bus_decoder_param_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_MASK = 32'hFFFF_0000;
  localparam logic [31:0] PLIC_BASE  = 32'h0C00_0000;
  localparam logic [31:0] PLIC_MASK  = 32'hFC00_0000;
  localparam logic [31:0] UART_BASE  = 32'h1000_0000;
  localparam logic [31:0] UART_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] SPI0_BASE  = 32'h1001_0000;
  localparam logic [31:0] SPI0_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] DTUBE_BASE = 32'h8000_0000;
  localparam logic [31:0] DTUBE_MASK = 32'hFFFF_FFF0;

  // Slave 0 sits in the least significant word.
  localparam logic [5*32-1:0] DEF_SLV_BASE =
    {DTUBE_BASE, SPI0_BASE, UART_BASE, PLIC_BASE, CLINT_BASE};
  localparam logic [5*32-1:0] DEF_SLV_MASK =
    {DTUBE_MASK, SPI0_MASK, UART_MASK, PLIC_MASK, CLINT_MASK};

  typedef enum logic [1:0] {
    D_NONE,
    D_SLV,
    D_ERR
  } dphase_e;

  typedef enum logic [1:0] {
    E_IDLE,
    E_ERR1,
    E_ERR2
  } err_e;

  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_bus_decoder_param_default_slave.sv
// Built-in AHB default slave: two-cycle ERROR response sequencer plus capture
// of the address that triggered it.
module ahb_default_slave
  import ahb_bus_decoder_param_pkg::*;
#(
  parameter int unsigned AW = WORD_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [AW-1:0] addr_i,
  output logic          hready_o,
  output logic [1:0]    hresp_o,
  output logic          dec_err_o,
  output logic [AW-1:0] dec_err_addr_o
);

  err_e          state_q, state_d;
  logic          dec_err_q, dec_err_d;
  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    state_d   = state_q;
    dec_err_d = start_i;
    addr_d    = start_i ? addr_i : addr_q;
    unique case (state_q)
      E_IDLE:  if (start_i) state_d = E_ERR1;
      E_ERR1:  state_d = E_ERR2;
      // ERR2 completes the response, so a new unmapped transfer may start here.
      E_ERR2:  state_d = start_i ? E_ERR1 : E_IDLE;
      default: state_d = E_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= E_IDLE;
      dec_err_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      dec_err_q <= dec_err_d;
      addr_q    <= addr_d;
    end
  end

  assign hready_o       = (state_q != E_ERR1);
  assign hresp_o        = (state_q == E_IDLE) ? HRESP_OKAY : HRESP_ERROR;
  assign dec_err_o      = dec_err_q;
  assign dec_err_addr_o = addr_q;

endmodule

// File: rtl/ahb_bus_decoder_param.sv
// Parametrised AHB address decoder and response mux with built-in default slave.
// Optional slave-stall timeout is enabled by defining AHB_DEC_TIMEOUT_EN.
module ahb_bus_decoder_param
  import ahb_bus_decoder_param_pkg::*;
#(
  parameter int unsigned            NSLV           = 5,
  parameter int unsigned            AW             = WORD_WIDTH,
  parameter logic [NSLV*AW-1:0]     SLV_BASE       = DEF_SLV_BASE,
  parameter logic [NSLV*AW-1:0]     SLV_MASK       = DEF_SLV_MASK,
  parameter int unsigned            TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        CPU_HADDR,
  input  logic [1:0]           CPU_HTRANS,
  input  logic [NSLV*AW-1:0]   S_HRDATA,
  input  logic [NSLV-1:0]      S_HREADY,
  input  logic [NSLV*2-1:0]    S_HRESP,
  output logic [NSLV-1:0]      HSEL,
  output logic [AW-1:0]        CPU_HRDATA,
  output logic                 CPU_HREADY,
  output logic [1:0]           CPU_HRESP,
  output logic                 DEC_ERR,
  output logic [AW-1:0]        DEC_ERR_ADDR
);

  localparam int unsigned IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  if (NSLV < 1 || NSLV > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("ahb_bus_decoder_param: NSLV must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  logic [NSLV-1:0] hit;
  logic            any_hit;
  logic [IW-1:0]   hit_idx;
  logic            active;
  logic            accept;

  dphase_e         state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic            slv_hready;
  logic [1:0]      slv_hresp;
  logic [AW-1:0]   slv_hrdata;

  logic            err_start;
  logic [AW-1:0]   err_addr;
  logic            err_hready;
  logic [1:0]      err_hresp;
  logic            to_fire;

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      hit[i] = ((CPU_HADDR & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]);
    end
  end

  // Lowest index wins on overlapping windows, keeping HSEL one-hot or zero.
  always_comb begin
    HSEL    = '0;
    hit_idx = '0;
    any_hit = 1'b0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (hit[i] && !any_hit) begin
        HSEL[i] = 1'b1;
        hit_idx = IW'(i);
        any_hit = 1'b1;
      end
    end
  end

  always_comb begin
    slv_hready = 1'b1;
    slv_hresp  = HRESP_OKAY;
    slv_hrdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (idx_q == IW'(i)) begin
        slv_hready = S_HREADY[i];
        slv_hresp  = S_HRESP[2*i +: 2];
        slv_hrdata = S_HRDATA[i*AW +: AW];
      end
    end
  end

  always_comb begin
    CPU_HREADY = 1'b1;
    CPU_HRESP  = HRESP_OKAY;
    CPU_HRDATA = '0;
    unique case (state_q)
      D_SLV: begin
        CPU_HREADY = slv_hready;
        CPU_HRESP  = slv_hresp;
        CPU_HRDATA = slv_hrdata;
      end
      D_ERR: begin
        CPU_HREADY = err_hready;
        CPU_HRESP  = err_hresp;
      end
      default: ;
    endcase
  end

  assign active    = htrans_active(CPU_HTRANS);
  assign accept    = CPU_HREADY;
  assign err_start = (accept && active && !any_hit) || to_fire;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (to_fire) begin
      state_d = D_ERR;
    end else if (accept) begin
      if (!active) begin
        state_d = D_NONE;
      end else if (any_hit) begin
        state_d = D_SLV;
        idx_d   = hit_idx;
      end else begin
        state_d = D_ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= D_NONE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef AHB_DEC_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [AW-1:0] dp_addr_q, dp_addr_d;
  logic          stall;

  // A stalled slave can never coincide with an acceptance, so clearing on
  // "not stalling" also covers the clear-on-acceptance case.
  assign stall   = (state_q == D_SLV) && !slv_hready;
  assign to_fire = stall && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d  = (stall && !to_fire) ? to_cnt_q + 1'b1 : '0;
    dp_addr_d = (accept && active && any_hit) ? CPU_HADDR : dp_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      dp_addr_q <= '0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      dp_addr_q <= dp_addr_d;
    end
  end

  assign err_addr = to_fire ? dp_addr_q : CPU_HADDR;
`else
  assign to_fire  = 1'b0;
  assign err_addr = CPU_HADDR;
`endif

  ahb_default_slave #(
    .AW (AW)
  ) u_default_slave (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (err_start),
    .addr_i         (err_addr),
    .hready_o       (err_hready),
    .hresp_o        (err_hresp),
    .dec_err_o      (DEC_ERR),
    .dec_err_addr_o (DEC_ERR_ADDR)
  );

endmodule

// File: doc/ahb_bus_decoder_param.md
Name: ahb_bus_decoder_param

Overview:
- Parametrised successor to the fixed five-slave AHB decoder.
- Decodes CPU_HADDR against NSLV base/mask windows and drives one-hot HSEL.
- Tracks the AHB data phase so it advances only on CPU_HREADY, then muxes the owning slave's response back to the CPU.
- Adds a built-in default slave that returns the AHB two-cycle ERROR response for unmapped active transfers, plus an unmapped-address status capture.

Parameters:
- NSLV, 5, number of slaves (1..8).
- AW, 32, address/data width (= `WORD_WIDTH).
- SLV_BASE, {NSLV*AW} packed, base address of slave i in bits [i*AW +: AW].
- SLV_MASK, {NSLV*AW} packed, decode mask of slave i; hit when (HADDR & MASK) == BASE.
- TIMEOUT_CYCLES, 256, stall limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- CPU_HADDR  in  AW  address-phase address
- CPU_HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- S_HRDATA  in  NSLV*AW  packed slave read data
- S_HREADY  in  NSLV  slave HREADYOUT
- S_HRESP  in  NSLV*2  packed slave response
- HSEL  out  NSLV  one-hot slave select, combinational
- CPU_HRDATA  out  AW  muxed read data
- CPU_HREADY  out  1  muxed ready; also fans out to slaves as HREADY
- CPU_HRESP  out  2  00 OKAY, 01 ERROR
- DEC_ERR  out  1  one-cycle pulse when an unmapped active transfer is accepted
- DEC_ERR_ADDR  out  AW  address of the last unmapped active transfer

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_n.
- Decode (combinational):
  - hit[i] = ((CPU_HADDR & MASK_i) == BASE_i).
  - HSEL is hit with the lowest index winning on overlap, so it is always one-hot or zero.
  - HSEL does not depend on HTRANS.
- Address-phase acceptance: a cycle with CPU_HREADY=1. Only accepted cycles update the data-phase state.
- Data-phase FSM states: D_NONE, D_SLV(idx), D_ERR1, D_ERR2. Reset state is D_NONE.
- On acceptance:
  - HTRANS IDLE or BUSY -> D_NONE.
  - Active transfer and some hit -> D_SLV, latch the index.
  - Active transfer and no hit -> D_ERR1. Also pulse DEC_ERR and latch DEC_ERR_ADDR <= CPU_HADDR.
- Outputs per state:
  - D_NONE: CPU_HREADY=1, CPU_HRESP=00, CPU_HRDATA=0.
  - D_SLV: forward S_HREADY, S_HRESP and S_HRDATA of the latched index. Hold the state while the slave's HREADY is 0.
  - D_ERR1: CPU_HREADY=0, CPU_HRESP=01. Always goes to D_ERR2 next cycle.
  - D_ERR2: CPU_HREADY=1, CPU_HRESP=01. This cycle is an acceptance cycle, so the next state is chosen from the current address phase.
- Back-to-back unmapped transfers: D_ERR2 -> D_ERR1 with a new DEC_ERR pulse.
- Reset values: HSEL follows decode; CPU_HREADY=1, CPU_HRESP=00, CPU_HRDATA=0, DEC_ERR=0, DEC_ERR_ADDR=0.
- Reset mid-transfer: the FSM returns to D_NONE immediately (asynchronous); the aborted slave response is ignored.
- Latency:
  - HSEL: zero cycles.
  - Response: follows the slave with no added cycles.
  - Unmapped access: exactly 2 data-phase cycles.

Optional Feature:
- Macro: AHB_DEC_TIMEOUT_EN.
- With the macro:
  - A counter (width $clog2(TIMEOUT_CYCLES)+1) counts consecutive D_SLV cycles with the selected S_HREADY=0.
  - Reaching TIMEOUT_CYCLES forces D_ERR1 (ERROR sequence, DEC_ERR pulse, DEC_ERR_ADDR = the stalled transfer's address). The slave's late response is ignored.
  - The counter clears on any acceptance or on leaving D_SLV.
- Without the macro: no counter; a stalled slave stalls the CPU indefinitely.

Decomposition:
- Shared defines in the bus defines header:
  - HTRANS encodings
  - HRESP_OKAY / HRESP_ERROR
  - default address map values (CLINT, PLIC, UART, SPI0, DTUBE base/mask)
- Sub-module ahb_default_slave: the D_ERR1/D_ERR2 sequencer plus the error-address capture, instantiated once.
- Decode and mux stay in the top module.

Test Plan:
- NSLV=5, default map. NONSEQ to the UART base with S_HREADY[2] low for 3 cycles -> HSEL=00100; CPU_HREADY low 3 cycles, then high with UART HRDATA=0xA5A5_0001 and HRESP=00.
- NONSEQ to 0xDEAD_0000 (unmapped) -> HSEL=0; next cycle HREADY=0/HRESP=01; following cycle HREADY=1/HRESP=01; DEC_ERR=1 for one cycle; DEC_ERR_ADDR=0xDEAD_0000.
- Two consecutive unmapped NONSEQs -> ERROR pair repeated; two DEC_ERR pulses; DEC_ERR_ADDR holds the second address.
- IDLE to an unmapped address -> zero-wait OKAY, no DEC_ERR.
- Overlapping windows for slaves 1 and 3, address hitting both -> HSEL=00010; slave 1 data returned.
- With AHB_DEC_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave 0 HREADY held low -> after 8 stall cycles, a 2-cycle ERROR pair and a DEC_ERR pulse. Assert rst_n low mid-stall -> CPU_HREADY=1 immediately.
